jstk2_spi_ctrl: RTL and testbench



---
 rtl/jstk2_pkg.sv | 22 ++
 rtl/spi_byte_shifter.sv | 70 +++++++
 rtl/jstk2_spi_ctrl.sv | 175 +++++++++++++++++
 tb/tb_jstk2_spi_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jstk2_pkg.sv
// Shared constants and state encoding for the PmodJSTK2 SPI controller.
package jstk2_pkg;

  localparam logic [7:0] CMD_SET_LED = 8'h84;

  localparam int DEF_HALF_CYC  = 90;
  localparam int DEF_SETUP_CYC = 180;
  localparam int DEF_GAP_CYC   = 120;
  localparam int DEF_HOLD_CYC  = 300;

  localparam int HALF_W  = 7;
  localparam int PHASE_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/spi_byte_shifter.sv
// One SPI mode-0 byte: generates SCLK, shifts MOSI out MSB first and MISO in.
module spi_byte_shifter
  import jstk2_pkg::*;
#(
  parameter int HALF_CYC = DEF_HALF_CYC
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic [7:0] rx_byte,
  output logic       byte_done
);

  logic [HALF_W-1:0] half_cnt_reg;
  logic [2:0]        bit_cnt_reg;
  logic              sclk_reg;
  logic [7:0]        tx_sr_reg;
  logic [7:0]        rx_sr_reg;
  logic              half_end;
  logic              rise;
  logic              fall;

  always_comb begin
    half_end  = (half_cnt_reg == HALF_W'(HALF_CYC - 1));
    rise      = en && !sclk_reg && half_end;
    fall      = en &&  sclk_reg && half_end;
    byte_done = fall && (bit_cnt_reg == 3'd7);
  end

  // A load always wins over shifting so the next byte's MSB is on MOSI
  // from the cycle after the previous byte's last falling edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      half_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      sclk_reg     <= 1'b0;
      tx_sr_reg    <= '0;
      rx_sr_reg    <= '0;
    end else if (load) begin
      half_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      sclk_reg     <= 1'b0;
      tx_sr_reg    <= load_byte;
    end else if (en) begin
      if (half_end) begin
        half_cnt_reg <= '0;
        sclk_reg     <= ~sclk_reg;
      end else begin
        half_cnt_reg <= half_cnt_reg + HALF_W'(1);
      end
      if (rise) begin
        rx_sr_reg <= {rx_sr_reg[6:0], miso};
      end
      if (fall) begin
        tx_sr_reg   <= {tx_sr_reg[6:0], 1'b0};
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end
    end
  end

  assign sclk    = sclk_reg;
  assign mosi    = tx_sr_reg[7];
  assign rx_byte = rx_sr_reg;

endmodule

// File: rtl/jstk2_spi_ctrl.sv
// PmodJSTK2 transaction sequencer: 5-byte SPI exchange with SS setup, gaps and hold,
// returning joystick X/Y and buttons.
module jstk2_spi_ctrl
  import jstk2_pkg::*;
#(
  parameter int HALF_CYC  = DEF_HALF_CYC,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [7:0]  CMD,
  input  logic [31:0] TX_DATA,
  input  logic        MISO,
  output logic        SS,
  output logic        SCLK,
  output logic        MOSI,
  output logic        BUSY,
  output logic        DONE,
  output logic [9:0]  X,
  output logic [9:0]  Y,
  output logic [1:0]  BTN
);

  state_t             state_reg, state_next;
  logic [PHASE_W-1:0] phase_reg, phase_next;
  logic [2:0]         idx_reg, idx_next;
  logic [39:0]        tx_reg, tx_next;
  logic [39:0]        rx_reg, rx_next;
  logic               ss_reg, ss_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [9:0]         x_reg, x_next;
  logic [9:0]         y_reg, y_next;
  logic [1:0]         btn_reg, btn_next;

  logic               load;
  logic [7:0]         load_byte;
  logic               byte_done;
  logic [7:0]         rx_byte;

  spi_byte_shifter #(
    .HALF_CYC (HALF_CYC)
  ) u_shifter (
    .CLK       (CLK),
    .RST       (RST),
    .en        (state_reg == ST_SHIFT),
    .load      (load),
    .load_byte (load_byte),
    .miso      (MISO),
    .sclk      (SCLK),
    .mosi      (MOSI),
    .rx_byte   (rx_byte),
    .byte_done (byte_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      phase_reg <= '0;
      idx_reg   <= '0;
      tx_reg    <= '0;
      rx_reg    <= '0;
      ss_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      x_reg     <= '0;
      y_reg     <= '0;
      btn_reg   <= '0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      idx_reg   <= idx_next;
      tx_reg    <= tx_next;
      rx_reg    <= rx_next;
      ss_reg    <= ss_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      btn_reg   <= btn_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    idx_next   = idx_reg;
    tx_next    = tx_reg;
    rx_next    = rx_reg;
    ss_next    = ss_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    x_next     = x_reg;
    y_next     = y_reg;
    btn_next   = btn_reg;
    load       = 1'b0;
    load_byte  = 8'h00;

    case (state_reg)
      ST_IDLE: begin
        // busy_reg is still high on the DONE cycle, which blocks a START there
        busy_next = 1'b0;
        if (START && !busy_reg) begin
          load       = 1'b1;
          load_byte  = CMD;
          tx_next    = {TX_DATA, 8'h00};
          idx_next   = '0;
          phase_next = '0;
          ss_next    = 1'b0;
          busy_next  = 1'b1;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (phase_reg == PHASE_W'(SETUP_CYC - 1)) begin
          phase_next = '0;
          state_next = ST_SHIFT;
        end else begin
          phase_next = phase_reg + PHASE_W'(1);
        end
      end
      ST_SHIFT: begin
        if (byte_done) begin
          rx_next    = {rx_reg[31:0], rx_byte};
          load       = 1'b1;
          phase_next = '0;
          if (idx_reg < 3'd4) begin
            load_byte  = tx_reg[39:32];
            tx_next    = {tx_reg[31:0], 8'h00};
            idx_next   = idx_reg + 3'd1;
            state_next = ST_GAP;
          end else begin
            ss_next    = 1'b1;
            state_next = ST_HOLD;
          end
        end
      end
      ST_GAP: begin
        if (phase_reg == PHASE_W'(GAP_CYC - 1)) begin
          phase_next = '0;
          state_next = ST_SHIFT;
        end else begin
          phase_next = phase_reg + PHASE_W'(1);
        end
      end
      ST_HOLD: begin
        if (phase_reg == PHASE_W'(HOLD_CYC - 1)) begin
          // rx_reg holds {rx0, rx1, rx2, rx3, rx4}
          phase_next = '0;
          done_next  = 1'b1;
          x_next     = {rx_reg[25:24], rx_reg[39:32]};
          y_next     = {rx_reg[9:8], rx_reg[23:16]};
          btn_next   = rx_reg[1:0];
          state_next = ST_IDLE;
        end else begin
          phase_next = phase_reg + PHASE_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign SS   = ss_reg;
  assign BUSY = busy_reg;
  assign DONE = done_reg;
  assign X    = x_reg;
  assign Y    = y_reg;
  assign BTN  = btn_reg;

endmodule

// File: tb/tb_jstk2_spi_ctrl.sv
// Scoreboard bench for jstk2_spi_ctrl: stimulus queues expected MOSI bytes and
// results; a negedge monitor checks them together with SPI timing.
module tb_jstk2_spi_ctrl;
  import jstk2_pkg::*;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] btn;
  } res_t;

  logic        CLK = 1'b0;
  logic        RST, START, MISO;
  logic [7:0]  CMD;
  logic [31:0] TX_DATA;
  logic        SS, SCLK, MOSI, BUSY, DONE;
  logic [9:0]  X, Y;
  logic [1:0]  BTN;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_n = 0;
  res_t        exp_q[$];
  logic [7:0]  mosi_q[$];
  logic [39:0] slave_data = '0;
  int          scnt = 0;

  jstk2_spi_ctrl dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .CMD     (CMD),
    .TX_DATA (TX_DATA),
    .MISO    (MISO),
    .SS      (SS),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .X       (X),
    .Y       (Y),
    .BTN     (BTN)
  );

  initial forever #5 CLK = ~CLK;
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Mode-0 slave: bit for the current position is presented from SS fall and
  // advances after every SCLK falling edge.
  assign MISO = (scnt < 40) ? slave_data[39 - scnt] : 1'b0;
  initial begin
    logic sclk_q;
    sclk_q = 1'b0;
    forever begin
      @(negedge CLK);
      if (SS !== 1'b0) scnt = 0;
      else if (sclk_q && !SCLK) scnt++;
      sclk_q = SCLK;
    end
  end

  // Monitor
  initial begin
    logic       ss_q, sclk_q;
    int         start_cyc, ss_fall_cyc, ss_rise_cyc, last_rise_cyc, fall8_cyc;
    int         rise_n, fall_n, mbits;
    logic [7:0] mbyte, mexp;
    res_t       e;
    ss_q = 1'b1; sclk_q = 1'b0;
    start_cyc = 0; ss_fall_cyc = 0; ss_rise_cyc = 0; last_rise_cyc = 0; fall8_cyc = 0;
    rise_n = 0; fall_n = 0; mbits = 0; mbyte = '0;
    forever begin
      @(negedge CLK);
      if (START === 1'b1 && BUSY === 1'b0 && RST === 1'b0) start_cyc = cyc;
      if (ss_q && SS === 1'b0) begin
        ss_fall_cyc = cyc; rise_n = 0; fall_n = 0; mbits = 0;
      end
      if (!ss_q && SS === 1'b1) ss_rise_cyc = cyc;
      if (!sclk_q && SCLK === 1'b1) begin
        rise_n++;
        if (rise_n == 1) chk("ss_to_first_rise", 32'(cyc - ss_fall_cyc), 32'd270);
        if (rise_n == 2) chk("sclk_period", 32'(cyc - last_rise_cyc), 32'd180);
        if (rise_n == 9) chk("byte_gap", 32'(cyc - fall8_cyc), 32'd210);
        last_rise_cyc = cyc;
        mbyte = {mbyte[6:0], MOSI};
        mbits++;
        if (mbits == 8) begin
          mbits = 0;
          if (mosi_q.size() == 0) begin
            chk("unexpected_mosi_byte", 32'(mbyte), 32'hFFFF_FFFF);
          end else begin
            mexp = mosi_q.pop_front();
            chk("mosi_byte", 32'(mbyte), 32'(mexp));
          end
        end
      end
      if (sclk_q && SCLK === 1'b0) begin
        fall_n++;
        if (fall_n == 8) fall8_cyc = cyc;
      end
      if (DONE === 1'b1) begin
        done_n++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done_n), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result_x", 32'(X), 32'(e.x));
          chk("result_y", 32'(Y), 32'(e.y));
          chk("result_btn", 32'(BTN), 32'(e.btn));
          chk("done_latency", 32'(cyc - start_cyc), 32'd8161);
          chk("ss_hold", 32'(cyc - ss_rise_cyc), 32'd300);
        end
      end
      ss_q = (SS === 1'b1);
      sclk_q = (SCLK === 1'b1);
    end
  end

  task automatic start_txn(input logic [7:0] cmd, input logic [31:0] tx,
                           input logic [39:0] slave, input logic [9:0] ex,
                           input logic [9:0] ey, input logic [1:0] ebtn);
    res_t r;
    r.x = ex; r.y = ey; r.btn = ebtn;
    slave_data = slave;
    CMD = cmd;
    TX_DATA = tx;
    mosi_q.push_back(cmd);
    mosi_q.push_back(tx[31:24]);
    mosi_q.push_back(tx[23:16]);
    mosi_q.push_back(tx[15:8]);
    mosi_q.push_back(tx[7:0]);
    exp_q.push_back(r);
    $display("txn cmd=%02h tx=%08h slave=%010h exp x=%03h y=%03h btn=%0d", cmd, tx, slave, ex, ey, ebtn);
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  // Leaves time at #1 after the edge that raised DONE, i.e. inside the DONE cycle.
  task automatic wait_done(input int max_cyc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge CLK);
      #1;
      if (DONE === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; CMD = '0; TX_DATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ss", 32'(SS), 32'd1);
    chk("rst_sclk", 32'(SCLK), 32'd0);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_xy", 32'({X, Y}), 32'd0);
    chk("rst_btn", 32'(BTN), 32'd0);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Basic transfer with an ignored START in the middle of byte 2
    start_txn(CMD_SET_LED, 32'hFF00_8000, 40'h34_02_CD_01_03, 10'h234, 10'h1CD, 2'b11);
    repeat (3900) @(posedge CLK);
    #1;
    chk("busy_mid_txn", 32'(BUSY), 32'd1);
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    wait_done(9000);
    repeat (8500) @(posedge CLK);
    #1;
    chk("single_done", 32'(done_n), 32'd1);
    chk("idle_after_busy_start", 32'(BUSY), 32'd0);

    // Reset in the middle of byte 3
    start_txn(8'h11, 32'h2233_4455, 40'hAA_BB_CC_DD_EE, 10'h0, 10'h0, 2'b00);
    repeat (5200) @(posedge CLK);
    #1;
    exp_q.delete();
    mosi_q.delete();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("abort_ss", 32'(SS), 32'd1);
    chk("abort_sclk", 32'(SCLK), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_xy_cleared", 32'({X, Y, BTN}), 32'd0);
    RST = 1'b0;
    repeat (5) @(posedge CLK);
    #1;

    // New transfer after abort; START on its DONE cycle must be ignored
    start_txn(8'h5A, 32'h0123_4567, 40'hA5_FF_3C_FE_01, 10'h3A5, 10'h23C, 2'b01);
    wait_done(9000);
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    chk("done_cycle_start_busy", 32'(BUSY), 32'd0);
    chk("done_cycle_start_ss", 32'(SS), 32'd1);
    repeat (3) @(posedge CLK);
    #1;

    // Back-to-back: second START on the first IDLE cycle after DONE
    start_txn(CMD_SET_LED, 32'h00FF_00AA, 40'h00_00_FF_03_02, 10'h000, 10'h3FF, 2'b10);
    wait_done(9000);
    @(posedge CLK);
    #1;
    chk("b2b_idle_busy", 32'(BUSY), 32'd0);
    start_txn(8'hC3, 32'h8001_7E18, 40'h7F_01_80_02_00, 10'h17F, 10'h280, 2'b00);
    chk("b2b_ss_low", 32'(SS), 32'd0);
    chk("b2b_busy", 32'(BUSY), 32'd1);
    wait_done(9000);
    repeat (5) @(posedge CLK);
    #1;

    chk("total_done", 32'(done_n), 32'd4);
    chk("results_drained", 32'(exp_q.size()), 32'd0);
    chk("mosi_drained", 32'(mosi_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
